ray_write_back_param: RTL and testbench

RAY_WRITE_BACK_PARAM -- requirements
Module: ray_write_back_param

---
 rtl/ray_write_back_param.sv | 117 +++++++++++
 tb/tb_ray_write_back_param.sv | 139 +++++++++++++
 2 files changed

// File: rtl/ray_write_back_param.sv
// ray_write_back_param: folds DEPTH diffuse terms through per-channel reflection coefficients,
// converts the Q16.16 result to 8-bit RGB and writes it to a frame buffer, counting frame pixels.
module ray_write_back_param #(
    parameter int DEPTH   = 5,
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int COORD_W = 11,
    parameter int ADDR_W  = 19
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [COORD_W-1:0]        image_x,
    input  logic [COORD_W-1:0]        image_y,
    input  logic [96*DEPTH-1:0]       diffuse_light_acc,
    input  logic [96*(DEPTH-1)-1:0]   reflection_coeffs,
    output logic                      wea,
    output logic [ADDR_W-1:0]         addra,
    output logic [23:0]               dina,
    output logic                      frame_done,
    output logic                      pixel_dropped
);
    localparam int KW = $clog2(DEPTH);
    localparam logic [COORD_W:0] XW = (COORD_W+1)'(WIDTH);
    localparam logic [COORD_W:0] YH = (COORD_W+1)'(HEIGHT);
    localparam logic [ADDR_W-1:0] AW = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH*HEIGHT-1);
    typedef enum logic [1:0] {IDLE, ACCUM, WRITE} state_t;
    state_t r_state, w_next;
    logic r_en;
    logic w_load, w_step, w_write, w_inr;
    logic [KW-1:0] r_k;
    logic [95:0] r_acc, w_acc_nxt;
    logic [96*DEPTH-1:0] r_diff;
    logic [96*(DEPTH-1)-1:0] r_coef;
    logic [COORD_W-1:0] r_x, r_y;
    logic [ADDR_W-1:0] r_cnt, r_addr;
    logic [23:0] r_dina, w_rgb;
    logic r_wea, r_fd, r_drop;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_en    <= 1'b1;
        end
    end
    always_comb begin
        w_next = (r_state == IDLE)  ? (w_load ? ACCUM : IDLE) :
                 (r_state == ACCUM) ? ((r_k == '0) ? WRITE : ACCUM) : IDLE;
    end
    always_comb begin
        in_ready = r_en && (r_state == IDLE);
        w_load   = in_valid && in_ready;
        w_step   = r_state == ACCUM;
        w_write  = r_state == WRITE;
    end
    // B at [31:0], G at [63:32], R at [95:64]; the same lane layout carries through to dina
    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic signed [31:0] w_a, w_cf, w_d, w_cv;
        logic [47:0] w_p;
        assign w_a  = r_acc[32*c +: 32];
        assign w_cf = r_coef[96*r_k + 32*c +: 32];
        assign w_d  = r_diff[96*r_k + 32*c +: 32];
        assign w_p  = {{16{w_cf[31]}}, w_cf} * {{16{w_a[31]}}, w_a};
        assign w_acc_nxt[32*c +: 32] = w_d + 32'(w_p >> 16);
        assign w_cv = (w_a >>> 16) - (w_a >>> 24);
        assign w_rgb[8*c +: 8] = w_cv[31] ? 8'h00 : (|w_cv[30:8]) ? 8'hFF : w_cv[7:0];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_k    <= '0;
            r_diff <= '0;
            r_coef <= '0;
            r_x    <= '0;
            r_y    <= '0;
        end else if (w_load) begin
            r_acc  <= diffuse_light_acc[96*(DEPTH-1) +: 96];
            r_k    <= KW'(DEPTH-2);
            r_diff <= diffuse_light_acc;
            r_coef <= reflection_coeffs;
            r_x    <= image_x;
            r_y    <= image_y;
        end else if (w_step) begin
            r_acc <= w_acc_nxt;
            r_k   <= r_k - 1'b1;
        end
    end
    assign w_inr = ({1'b0, r_x} < XW) && ({1'b0, r_y} < YH);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wea  <= 1'b0;
            r_fd   <= 1'b0;
            r_drop <= 1'b0;
            r_addr <= '0;
            r_dina <= '0;
            r_cnt  <= '0;
        end else begin
            r_wea  <= w_write && w_inr;
            r_fd   <= w_write && w_inr && (r_cnt == LAST);
            r_drop <= w_write && !w_inr;
            if (w_write && w_inr) begin
                r_addr <= ADDR_W'(r_x) + ADDR_W'(r_y) * AW;
                r_dina <= w_rgb;
                r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
            end
        end
    end
    assign wea           = r_wea;
    assign addra         = r_addr;
    assign dina          = r_dina;
    assign frame_done    = r_fd;
    assign pixel_dropped = r_drop;
endmodule

// File: tb/tb_ray_write_back_param.sv
// tb_ray_write_back_param: directed checks on three configurations (DEPTH=2 full frame,
// DEPTH=2 4x2 frame, DEPTH=5 full frame) with hand-computed results.
module tb_ray_write_back_param;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;
    logic va = 1'b0, vb = 1'b0, vc = 1'b0;
    logic [10:0] px = '0, py = '0;
    logic [191:0] d2 = '0;
    logic [95:0] c2 = '0;
    logic [479:0] d5 = '0;
    logic [383:0] c5 = '0;
    logic ra, wa, fda, dra, rb, wb, fdb, drb, rc, wc, fdc, drc;
    logic [18:0] aa, ac;
    logic [2:0] ab;
    logic [23:0] da, db, dc;
    int n_chk = 0, n_fail = 0;

    ray_write_back_param #(.DEPTH(2)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(ra), .image_x(px), .image_y(py),
        .diffuse_light_acc(d2), .reflection_coeffs(c2), .wea(wa), .addra(aa), .dina(da),
        .frame_done(fda), .pixel_dropped(dra));
    ray_write_back_param #(.DEPTH(2), .WIDTH(4), .HEIGHT(2), .ADDR_W(3)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_ready(rb), .image_x(px), .image_y(py),
        .diffuse_light_acc(d2), .reflection_coeffs(c2), .wea(wb), .addra(ab), .dina(db),
        .frame_done(fdb), .pixel_dropped(drb));
    ray_write_back_param #(.DEPTH(5)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(vc), .in_ready(rc), .image_x(px), .image_y(py),
        .diffuse_light_acc(d5), .reflection_coeffs(c5), .wea(wc), .addra(ac), .dina(dc),
        .frame_done(fdc), .pixel_dropped(drc));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic set2(input logic [10:0] x, y, input logic [95:0] d1, c0, d0);
        px = x; py = y; d2 = {d1, d0}; c2 = c0;
    endtask
    // one DEPTH=2 pixel into u_a; returns on the negedge where wea is high
    task automatic go_a(input logic [10:0] x, y, input logic [95:0] d1, c0, d0);
        set2(x, y, d1, c0, d0);
        va = 1'b1; tick(1); va = 1'b0; tick(2);
    endtask
    // one pixel of constant 32.0 into u_b (dina 0x202020)
    task automatic go_b(input logic [10:0] x, y);
        set2(x, y, {3{32'h00100000}}, 96'h0, {3{32'h00200000}});
        vb = 1'b1; tick(1); vb = 1'b0; tick(2);
    endtask

    initial begin
        #3 rst_n = 1'b0;
        tick(2);
        chk("rst_ready", ra, 0); chk("rst_wea", wa, 0); chk("rst_addr", aa, 0);
        chk("rst_dina", da, 0); chk("rst_fd", fda, 0); chk("rst_drop", dra, 0);
        rst_n = 1'b1;
        tick(1);
        chk("ready_after_rst", ra, 1);
        // 100.0 * 0.5 + 10.0 = 60.0 on every channel
        set2(11'd3, 11'd2, {3{32'h00640000}}, {3{32'h00008000}}, {3{32'h000A0000}});
        va = 1'b1; tick(1); va = 1'b0;
        chk("busy_ready", ra, 0); chk("wea_n0", wa, 0);
        tick(1);
        chk("wea_n1", wa, 0);
        tick(1);
        chk("wea_n2", wa, 1); chk("addr_1283", aa, 1283); chk("dina_3c", da, 24'h3C3C3C);
        chk("fd_a0", fda, 0); chk("drop_a0", dra, 0);
        tick(1);
        chk("wea_one_cycle", wa, 0); chk("addr_hold", aa, 1283); chk("dina_hold", da, 24'h3C3C3C);
        chk("ready_back", ra, 1);
        // R: -100*0.5+200=150, G: 20*2+1=41, B: 64*-1+100=36
        go_a(11'd639, 11'd479, {32'hFF9C0000, 32'h00140000, 32'h00400000},
             {32'h00008000, 32'h00020000, 32'hFFFF0000}, {32'h00C80000, 32'h00010000, 32'h00640000});
        chk("mix_wea", wa, 1); chk("mix_addr", aa, 307199); chk("mix_dina", da, 24'h962924);
        // zero coefficient passes diffuse[0]: 300.0 -> 255, -5.0 -> 0, 127.0 -> 127
        go_a(11'd5, 11'd0, {3{32'h7FFF0000}}, 96'h0, {32'h012C0000, 32'hFFFB0000, 32'h007F0000});
        chk("clamp_dina", da, 24'hFF007F); chk("clamp_addr", aa, 5);
        tick(1);
        // DEPTH=5, diffuse[k]=k, coeff=2.0: 4 -> 11 -> 24 -> 49 -> 98
        for (int k = 0; k < 5; k++) d5[96*k +: 96] = {3{32'(k << 16)}};
        c5 = {12{32'h00020000}};
        px = 11'd10; py = 11'd1;
        vc = 1'b1;
        for (int i = 0; i < 13; i++) begin
            chk("c_ready", rc, 32'(i % 6 == 0));
            chk("c_wea", wc, 32'((i % 6 == 0) && i > 0));
            if (i == 6) begin
                chk("c_addr", ac, 650); chk("c_dina", dc, 24'h626262);
            end
            tick(1);
        end
        vc = 1'b0;
        tick(8);
        for (int i = 0; i < 8; i++) begin
            go_b(11'(i % 4), 11'(i / 4));
            chk("b_wea", wb, 1); chk("b_addr", ab, 32'(i)); chk("b_fd", fdb, 32'(i == 7));
            if (i == 2) begin
                go_b(11'd4, 11'd0);
                chk("dropx_wea", wb, 0); chk("dropx_strobe", drb, 1); chk("dropx_fd", fdb, 0);
                tick(1);
                chk("drop_pulse", drb, 0);
                go_b(11'd0, 11'd2);
                chk("dropy_wea", wb, 0); chk("dropy_strobe", drb, 1);
            end
        end
        tick(1);
        chk("fd_pulse", fdb, 0); chk("b_wea_low", wb, 0);
        go_b(11'd1, 11'd1);
        chk("ninth_wea", wb, 1); chk("ninth_addr", ab, 5); chk("ninth_fd", fdb, 0);
        chk("b_dina", db, 24'h202020);
        go_b(11'd2, 11'd1);
        go_b(11'd3, 11'd1);
        set2(11'd2, 11'd0, {3{32'h00100000}}, 96'h0, {3{32'h00200000}});
        vb = 1'b1; tick(1); vb = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wea", wb, 0); chk("mid_rst_addr", ab, 0); chk("mid_rst_dina", db, 0);
        chk("mid_rst_fd", fdb, 0); chk("mid_rst_drop", drb, 0); chk("mid_rst_ready", rb, 0);
        chk("mid_rst_a_addr", aa, 0); chk("mid_rst_a_dina", da, 0);
        tick(2);
        chk("rst_hold_wea", wb, 0);
        rst_n = 1'b1;
        tick(1);
        chk("b_ready_after_rst", rb, 1);
        tick(2);
        chk("discarded", wb, 0);
        for (int i = 0; i < 8; i++) begin
            go_b(11'(i % 4), 11'(i / 4));
            chk("rf_wea", wb, 1); chk("rf_fd", fdb, 32'(i == 7));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
